// File: rtl/addv_digit_serial.sv
`default_nettype none
// ============================================================================
//  Module      : addv_digit_serial
//  Description : Digit-serial two's-complement adder with carry-in and signed
//                overflow flag. Adds DIGIT bits per cycle through a registered
//                carry, with valid/ready handshakes on input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
module addv_digit_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             v_o
);

    // Number of digit steps, padded operand width and counter width.
    localparam int c_ndig      = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int c_pad_w     = c_ndig * DIGIT;
    localparam int c_cnt_w     = (c_ndig > 1) ? $clog2(c_ndig) : 1;
    // Number of real (non-padding) bits in the final digit.
    localparam int c_last_bits = WIDTH - (c_ndig - 1) * DIGIT;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_ndig - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_s;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_v;

    int                 w_base;
    logic [c_pad_w-1:0] w_a_pad;
    logic [c_pad_w-1:0] w_b_pad;
    logic [DIGIT:0]     w_slice_sum;
    logic               w_last;
    logic [WIDTH-1:0]   w_s_new;
    logic               w_carry;
    logic               w_v;

    // Handshake and result outputs come straight from registered state.
    assign in_ready_o  = (r_state == c_st_idle);
    assign out_valid_o = (r_state == c_st_done);
    assign s_o         = r_s;
    assign v_o         = r_v;

    // Datapath for one digit step: slice add, merge into sum, carry/overflow.
    always_comb begin
        w_base  = int'(r_cnt) * DIGIT;
        // Zero padding above WIDTH keeps a partial last digit from adding junk.
        w_a_pad = '0;
        w_b_pad = '0;
        w_a_pad[WIDTH-1:0] = r_a;
        w_b_pad[WIDTH-1:0] = r_b;
        w_slice_sum = {1'b0, w_a_pad[w_base +: DIGIT]}
                    + {1'b0, w_b_pad[w_base +: DIGIT]}
                    + (DIGIT+1)'(r_carry);
        w_last  = (r_cnt == c_cnt_last);
        // Only bits below WIDTH are written; the rest of the sum is kept.
        w_s_new = r_s;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i >= w_base) && (i < w_base + DIGIT)) begin
                w_s_new[i] = w_slice_sum[i - w_base];
            end
        end
        // On a partial last digit the carry out of bit WIDTH-1 sits lower.
        w_carry = w_last ? w_slice_sum[c_last_bits] : w_slice_sum[DIGIT];
        w_v     = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s_new[WIDTH-1] != r_a[WIDTH-1]);
    end

    // Control FSM and operand/result registers; reset aborts any operation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid_i) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_carry <= ci_i;
                        r_cnt   <= '0;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_s     <= w_s_new;
                    r_carry <= w_carry;
                    if (w_last) begin
                        r_v     <= w_v;
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_done: begin
                    if (out_ready_i) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addv_digit_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addv_digit_serial
//  Description : Self-checking bench for addv_digit_serial. Five instances
//                cover width/digit = 8/4, 10/4, 8/1, 8/3, 8/8; results are
//                compared with an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addv_digit_serial;

    localparam int c_ninst = 5;

    logic       clk;
    logic       rst;
    logic       in_valid  [c_ninst];
    logic       in_ready  [c_ninst];
    logic [9:0] a_d       [c_ninst];
    logic [9:0] b_d       [c_ninst];
    logic       ci_d      [c_ninst];
    logic       out_valid [c_ninst];
    logic       out_ready [c_ninst];
    logic [9:0] s_out     [c_ninst];
    logic       v_out     [c_ninst];

    int n_total;
    int n_bad;

    function automatic int cfg_w(input int k);
        return (k == 1) ? 10 : 8;
    endfunction

    function automatic int cfg_d(input int k);
        return (k <= 1) ? 4 : (k == 2) ? 1 : (k == 3) ? 3 : 8;
    endfunction

    for (genvar gi = 0; gi < c_ninst; gi++) begin : g_dut
        localparam int W = (gi == 1) ? 10 : 8;
        localparam int D = (gi <= 1) ? 4 : (gi == 2) ? 1 : (gi == 3) ? 3 : 8;
        logic [W-1:0] s_loc;
        addv_digit_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (in_valid[gi]),
            .in_ready_o  (in_ready[gi]),
            .a_i         (a_d[gi][W-1:0]),
            .b_i         (b_d[gi][W-1:0]),
            .ci_i        (ci_d[gi]),
            .out_valid_o (out_valid[gi]),
            .out_ready_i (out_ready[gi]),
            .s_o         (s_loc),
            .v_o         (v_out[gi])
        );
        assign s_out[gi] = 10'(s_loc);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer sum, and signed range test for overflow.
    task automatic model(input int k, input logic [9:0] a, input logic [9:0] b,
                         input logic ci, output logic [9:0] s, output logic v);
        longint w, ua, ub, sa, sb, full, smin, smax;
        w    = cfg_w(k);
        ua   = longint'(a) & ((64'd1 << w) - 1);
        ub   = longint'(b) & ((64'd1 << w) - 1);
        full = ua + ub + longint'(ci);
        s    = 10'(full & ((64'd1 << w) - 1));
        sa   = (ua >= (64'd1 << (w - 1))) ? ua - (64'd1 << w) : ua;
        sb   = (ub >= (64'd1 << (w - 1))) ? ub - (64'd1 << w) : ub;
        smax = (64'd1 << (w - 1)) - 1;
        smin = -(64'd1 << (w - 1));
        full = sa + sb + longint'(ci);
        v    = (full > smax) || (full < smin);
    endtask

    // One full operation on instance k; called #1 after a rising edge.
    task automatic run_op(input int k, input logic [9:0] a, input logic [9:0] b,
                          input logic ci, input int hold);
        logic [9:0] es;
        logic       ev;
        int         ndig, cyc;
        ndig = (cfg_w(k) + cfg_d(k) - 1) / cfg_d(k);
        model(k, a, b, ci, es, ev);
        chk($sformatf("k%0d ready_idle", k), 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        a_d[k]      = a;
        b_d[k]      = b;
        ci_d[k]     = ci;
        @(posedge clk); #1;
        // Operands need only be stable at the accept edge.
        in_valid[k] = 1'b0;
        a_d[k]      = 10'($urandom);
        b_d[k]      = 10'($urandom);
        ci_d[k]     = 1'($urandom);
        cyc = 0;
        while (!out_valid[k] && cyc < 40) begin
            chk($sformatf("k%0d ready_run", k), 32'(in_ready[k]), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("k%0d latency", k), 32'(cyc), 32'(ndig));
        for (int h = 0; h < hold; h++) begin
            chk($sformatf("k%0d hold_valid", k), 32'(out_valid[k]), 32'd1);
            chk($sformatf("k%0d hold_ready", k), 32'(in_ready[k]), 32'd0);
            chk($sformatf("k%0d hold_s", k), 32'(s_out[k]), 32'(es));
            chk($sformatf("k%0d hold_v", k), 32'(v_out[k]), 32'(ev));
            in_valid[k] = (h % 2 == 0);
            a_d[k]      = 10'($urandom);
            @(posedge clk); #1;
        end
        in_valid[k] = 1'b0;
        chk($sformatf("k%0d valid", k), 32'(out_valid[k]), 32'd1);
        chk($sformatf("k%0d sum a=%0h b=%0h ci=%0d", k, a, b, ci), 32'(s_out[k]), 32'(es));
        chk($sformatf("k%0d ovf a=%0h b=%0h ci=%0d", k, a, b, ci), 32'(v_out[k]), 32'(ev));
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk($sformatf("k%0d back_idle", k), 32'(in_ready[k]), 32'd1);
        chk($sformatf("k%0d valid_drop", k), 32'(out_valid[k]), 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        for (int k = 0; k < c_ninst; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            a_d[k]       = '0;
            b_d[k]       = '0;
            ci_d[k]      = 1'b0;
        end
        #1;
        for (int k = 0; k < c_ninst; k++) begin
            chk($sformatf("k%0d rst_ready", k), 32'(in_ready[k]), 32'd1);
            chk($sformatf("k%0d rst_valid", k), 32'(out_valid[k]), 32'd0);
            chk($sformatf("k%0d rst_s", k), 32'(s_out[k]), 32'd0);
            chk($sformatf("k%0d rst_v", k), 32'(v_out[k]), 32'd0);
        end
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, 8/4.
        run_op(0, 10'h07F, 10'h001, 1'b0, 0);
        run_op(0, 10'h0FF, 10'h001, 1'b0, 0);
        run_op(0, 10'h080, 10'h080, 1'b0, 0);
        run_op(0, 10'h00F, 10'h000, 1'b1, 0);
        run_op(0, 10'h000, 10'h0FF, 1'b1, 0);
        // Backpressure with ignored input pulses.
        run_op(0, 10'h05A, 10'h033, 1'b1, 5);
        // Partial last digit, 10/4.
        run_op(1, 10'h1FF, 10'h001, 1'b0, 0);
        run_op(1, 10'h3FF, 10'h3FF, 1'b0, 0);

        // Reset during the second RUN cycle.
        in_valid[0] = 1'b1;
        a_d[0]      = 10'h013;
        b_d[0]      = 10'h024;
        ci_d[0]     = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort valid", 32'(out_valid[0]), 32'd0);
        chk("abort ready", 32'(in_ready[0]), 32'd1);
        chk("abort s", 32'(s_out[0]), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_op(0, 10'h003, 10'h004, 1'b0, 1);

        // Randomised operations on every configuration.
        for (int k = 0; k < c_ninst; k++) begin
            for (int n = 0; n < 25; n++) begin
                run_op(k, 10'($urandom), 10'($urandom), 1'($urandom),
                       int'($urandom_range(0, 2)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
